// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the dmem arbiter: port ids and response tags.
package dmem_arb_pkg;

    localparam int DMEM_AW = 12;
    localparam int DMEM_DW = 32;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_AUX = 1'b1
    } port_e;

    typedef struct packed {
        logic  valid;
        port_e port;
    } rsp_tag_t;

    localparam rsp_tag_t RSP_IDLE = '{valid: 1'b0, port: PORT_CPU};

endpackage

// File: rtl/dmem_arb_rsp_pipe.sv
// Fixed-depth shift register of read-response tags; the head tag marks the
// cycle in which the dmem output belongs to an accepted read.
module dmem_arb_rsp_pipe
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clock,
    input  logic     reset,
    input  rsp_tag_t push,
    output rsp_tag_t head
);

    rsp_tag_t [DEPTH-1:0] stage_p1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage_p1 <= '0;
        end else begin
            stage_p1[0] <= push;
            for (int i = DEPTH - 1; i > 0; i--) begin
                stage_p1[i] <= stage_p1[i-1];
            end
        end
    end

    assign head = stage_p1[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU / AUX) arbiter owning the single-port dmem inputs.
// Define DMEM_ARB_RR_EN for round-robin ties; otherwise the CPU always wins ties.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW     = DMEM_AW,
    parameter int DW     = DMEM_DW,
    parameter int RD_LAT = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    input  logic          aux_req,
    input  logic          aux_we,
    input  logic [AW-1:0] aux_addr,
    input  logic [DW-1:0] aux_wdata,
    output logic          aux_gnt,
    output logic          aux_rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data,
    output logic          mem_wren,
    input  logic [DW-1:0] mem_q
);

    localparam int PIPE_DEPTH = 1 + RD_LAT;

    logic          run_p0;
    logic          cpu_win_p0;
    logic          aux_win_p0;
    logic          accept_p0;
    logic          sel_we_p0;
    logic [AW-1:0] sel_addr_p0;
    logic [DW-1:0] sel_wdata_p0;
    rsp_tag_t      push_tag_p0;
    rsp_tag_t      head_tag;
    logic [DW-1:0] rdata_hold;

    // Grants stay off until the first clock edge after reset is released.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_p0 <= 1'b0;
        end else begin
            run_p0 <= 1'b1;
        end
    end

`ifdef DMEM_ARB_RR_EN
    port_e last_p0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_p0 <= PORT_AUX;
        end else if (accept_p0) begin
            last_p0 <= aux_win_p0 ? PORT_AUX : PORT_CPU;
        end
    end
`endif

    // Stage p0: arbitration and selection of the winning request.
    always_comb begin
        cpu_win_p0 = 1'b0;
        aux_win_p0 = 1'b0;
        if (run_p0) begin
            if (cpu_req && aux_req) begin
`ifdef DMEM_ARB_RR_EN
                if (last_p0 == PORT_CPU) begin
                    aux_win_p0 = 1'b1;
                end else begin
                    cpu_win_p0 = 1'b1;
                end
`else
                cpu_win_p0 = 1'b1;
`endif
            end else begin
                cpu_win_p0 = cpu_req;
                aux_win_p0 = aux_req;
            end
        end
    end

    assign cpu_gnt      = cpu_win_p0;
    assign aux_gnt      = aux_win_p0;
    assign accept_p0    = cpu_win_p0 | aux_win_p0;
    assign sel_we_p0    = aux_win_p0 ? aux_we    : cpu_we;
    assign sel_addr_p0  = aux_win_p0 ? aux_addr  : cpu_addr;
    assign sel_wdata_p0 = aux_win_p0 ? aux_wdata : cpu_wdata;

    always_comb begin
        push_tag_p0.valid = accept_p0 & ~sel_we_p0;
        push_tag_p0.port  = aux_win_p0 ? PORT_AUX : PORT_CPU;
    end

    // Stage p1: registered access toward dmem; address/data hold when idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
        end else if (accept_p0) begin
            mem_address <= sel_addr_p0;
            mem_data    <= sel_wdata_p0;
            mem_wren    <= sel_we_p0;
        end else begin
            mem_wren    <= 1'b0;
        end
    end

    dmem_arb_rsp_pipe #(
        .DEPTH (PIPE_DEPTH)
    ) u_rsp_pipe (
        .clock (clock),
        .reset (reset),
        .push  (push_tag_p0),
        .head  (head_tag)
    );

    // Return stage: dmem output passes straight through on a tagged return,
    // otherwise the last returned word is presented.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_hold <= '0;
        end else if (head_tag.valid) begin
            rdata_hold <= mem_q;
        end
    end

    assign rdata      = head_tag.valid ? mem_q : rdata_hold;
    assign cpu_rvalid = head_tag.valid && (head_tag.port == PORT_CPU);
    assign aux_rvalid = head_tag.valid && (head_tag.port == PORT_AUX);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural dmem model.
// Tie expectations follow DMEM_ARB_RR_EN when it is defined for the build.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW     = 12;
    localparam int DW     = 32;
    localparam int RD_LAT = 1;

    logic          clock;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          aux_req, aux_we, aux_gnt, aux_rvalid;
    logic [AW-1:0] aux_addr;
    logic [DW-1:0] aux_wdata;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_wren;
    logic [DW-1:0] mem_q;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [int];
    logic [31:0] mem [0:4095];
    logic [31:0] q_pipe [RD_LAT];

    dmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_rvalid  (cpu_rvalid),
        .aux_req     (aux_req),
        .aux_we      (aux_we),
        .aux_addr    (aux_addr),
        .aux_wdata   (aux_wdata),
        .aux_gnt     (aux_gnt),
        .aux_rvalid  (aux_rvalid),
        .rdata       (rdata),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural single-port syncram with RD_LAT registered read stages.
    always @(posedge clock) begin
        if (mem_wren) mem[mem_address] <= mem_data;
        q_pipe[0] <= mem[mem_address];
        for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
    end
    assign mem_q = q_pipe[RD_LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
    endfunction

    task automatic expect_op(input logic port, input logic we, input logic [AW-1:0] a,
                             input logic [31:0] d);
        exp_t e;
        if (we) begin
            ref_mem[int'(a)] = d;
        end else begin
            e.port = port;
            e.data = ref_rd(a);
            e.due  = cyc + 1 + RD_LAT;
            exp_q.push_back(e);
        end
    endtask

    task automatic step(input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [31:0] cd,
                        input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [31:0] ad,
                        input logic ecg, input logic eag, input string tag);
        @(negedge clock);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        aux_req = ar; aux_we = aw; aux_addr = aa; aux_wdata = ad;
        #2;
        check({tag, "_cpu_gnt"}, {31'b0, cpu_gnt}, {31'b0, ecg});
        check({tag, "_aux_gnt"}, {31'b0, aux_gnt}, {31'b0, eag});
        if (ecg) expect_op(1'b0, cw, ca, cd);
        if (eag) expect_op(1'b1, aw, aa, ad);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cpu_gnt"},     {31'b0, cpu_gnt},    32'h0);
        check({tag, "_aux_gnt"},     {31'b0, aux_gnt},    32'h0);
        check({tag, "_cpu_rvalid"},  {31'b0, cpu_rvalid}, 32'h0);
        check({tag, "_aux_rvalid"},  {31'b0, aux_rvalid}, 32'h0);
        check({tag, "_rdata"},       rdata,               32'h0);
        check({tag, "_mem_address"}, {20'b0, mem_address}, 32'h0);
        check({tag, "_mem_data"},    mem_data,            32'h0);
        check({tag, "_mem_wren"},    {31'b0, mem_wren},   32'h0);
    endtask

    // Monitor: every returned read is matched against the oldest expectation.
    always @(negedge clock) begin
        exp_t e;
        if (cpu_rvalid || aux_rvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid: got cpu=%0b aux=%0b rdata=0x%08h, want no return (cycle %0d)",
                         cpu_rvalid, aux_rvalid, rdata, cyc);
            end else begin
                e = exp_q.pop_front();
                check("rsp_port", {30'b0, cpu_rvalid, aux_rvalid}, e.port ? 32'h1 : 32'h2);
                check("rsp_rdata", rdata, e.data);
                check("rsp_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, want finish within bound");
        $fatal(1);
    end

    initial begin
        bit tie_cpu;
        int ci, ai, wait_n;

        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        for (int i = 0; i < RD_LAT; i++) q_pipe[i] = 32'h0;
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        aux_req = 0; aux_we = 0; aux_addr = '0; aux_wdata = '0;

        // Reset state with both requests raised.
        repeat (2) @(negedge clock);
        cpu_req = 1; aux_req = 1;
        #2;
        check_all_zero("reset");
        @(negedge clock);
        cpu_req = 0; aux_req = 0;
        reset = 1'b0;
        idle(1);

        // CPU write then read of 0x010.
        step(1, 1, 12'h010, 32'h0000_00AB, 0, 0, 0, 0, 1, 0, "cpu_wr");
        step(1, 0, 12'h010, 32'h0,         0, 0, 0, 0, 1, 0, "cpu_rd");
        idle(3);

        // Preload distinct words for the tie test; AUX goes last.
        for (int i = 0; i < 6; i++)
            step(1, 1, 12'h020 + 12'(i), 32'hC000_0020 + i, 0, 0, 0, 0, 1, 0, "pre_cpu");
        for (int i = 0; i < 6; i++)
            step(0, 0, 0, 0, 1, 1, 12'h030 + 12'(i), 32'hA000_0030 + i, 0, 1, "pre_aux");

        // Both ports read continuously for 6 cycles.
        ci = 0; ai = 0;
        for (int k = 0; k < 6; k++) begin
`ifdef DMEM_ARB_RR_EN
            tie_cpu = (k % 2 == 0);
`else
            tie_cpu = 1'b1;
`endif
            step(1, 0, 12'h020 + 12'(ci), 0, 1, 0, 12'h030 + 12'(ai), 0, tie_cpu, !tie_cpu, "tie");
            if (tie_cpu) ci++; else ai++;
        end
        step(0, 0, 0, 0, 1, 0, 12'h030 + 12'(ai), 0, 0, 1, "tie_aux_after");
        idle(4);

        // AUX write to 0xFFF immediately followed by CPU read.
        step(0, 0, 0, 0, 1, 1, 12'hFFF, 32'hDEAD_BEEF, 0, 1, "wr_aux");
        step(1, 0, 12'hFFF, 0, 0, 0, 0, 0, 1, 0, "rd_cpu");
        idle(3);

        // Reset one cycle after a CPU read grant.
        step(1, 0, 12'h021, 0, 0, 0, 0, 0, 1, 0, "pre_rst_rd");
        @(negedge clock);
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h022;
        aux_req = 1; aux_we = 0; aux_addr = 12'h032;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_all_zero("rst_mid");
        @(negedge clock);
        #1;
        check_all_zero("rst_hold");
        @(negedge clock);
        reset = 1'b0;
        #2;
        check("rst_rel_cpu_gnt", {31'b0, cpu_gnt}, 32'h0);
        check("rst_rel_aux_gnt", {31'b0, aux_gnt}, 32'h0);
        step(1, 0, 12'h022, 0, 1, 0, 12'h032, 0, 1, 0, "rst_tie");
        idle(3);

        // AUX write raised and withdrawn while the CPU holds priority.
        step(0, 0, 0, 0, 1, 0, 12'h030, 0, 0, 1, "wd_aux_rd");
        step(1, 0, 12'h040, 0, 1, 1, 12'h041, 32'h5555_5555, 1, 0, "wd_tie");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "wd_drop");
        check("wd_mem_wren", {31'b0, mem_wren}, 32'h0);
        step(1, 0, 12'h041, 0, 0, 0, 0, 0, 1, 0, "wd_rd");
        check("wd_mem_wren2", {31'b0, mem_wren}, 32'h0);
        idle(3);
        check("wd_mem_unchanged", mem[12'h041], 32'h0);

        // Every expected return must have arrived.
        wait_n = 0;
        while (exp_q.size() != 0 && wait_n < 10) begin
            @(negedge clock);
            wait_n++;
        end
        check("pending_returns", exp_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
